// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared opcodes, state type and mux encodings
package multicycle_controller_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_JALR_LINK,
    S_JALR_TGT,
    S_JALR_PC,
    S_TRAP
  } state_t;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_REG    = 2'b10;

  localparam logic [1:0] SRC_B_WDATA  = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;

  localparam logic [1:0] ALU_ADD      = 2'b00;
  localparam logic [1:0] ALU_SUB      = 2'b01;
  localparam logic [1:0] ALU_FUNCT    = 2'b10;

  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_DATA     = 2'b01;
  localparam logic [1:0] RES_ALU_RES  = 2'b10;

  localparam logic [1:0] IMM_I        = 2'b00;
  localparam logic [1:0] IMM_S        = 2'b01;
  localparam logic [1:0] IMM_B        = 2'b10;
  localparam logic [1:0] IMM_J        = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// rtl/imm_src_decoder.sv - combinational opcode to immediate-format select
module imm_src_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  // Immediate format by opcode; R-type and unknown opcodes fall back to I
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM with retire counter and trap
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_update,
  output logic             branch,
  output logic             ir_wr,
  output logic             reg_wr,
  output logic             mem_wr,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_opcode,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_next;

  imm_src_decoder u_imm_src_decoder (
    .opcode  (opcode),
    .imm_src (imm_src)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Retire on every entry into FETCH; latch the trap flag on entry into TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      if (state_next == S_FETCH && state != S_FETCH) retired <= retired + CNT_ONE;
      if (state_next == S_TRAP && state != S_TRAP)   illegal <= 1'b1;
    end
  end

  // Next-state and Moore outputs; only FETCH looks at mem_ready for its outputs
  always_comb begin
    state_next = state;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_WDATA;
    alu_opcode = ALU_ADD;
    result_src = RES_ALU_OUT;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_RES;
        ir_wr      = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR_LINK;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a  = SRC_A_REG;
        alu_src_b  = SRC_B_IMM;
        state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = RES_DATA;
        reg_wr     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        adr_src = 1'b1;
        mem_wr  = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = SRC_A_REG;
        alu_opcode = ALU_FUNCT;
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRC_A_REG;
        alu_src_b  = SRC_B_IMM;
        alu_opcode = ALU_FUNCT;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_wr     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_REG;
        alu_opcode = ALU_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALU_WB;
      end
      S_JALR_LINK: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        state_next = S_JALR_TGT;
      end
      S_JALR_TGT: begin
        // Link goes to rd while the target is computed from A latched in DECODE
        alu_src_a  = SRC_A_REG;
        alu_src_b  = SRC_B_IMM;
        reg_wr     = 1'b1;
        state_next = S_JALR_PC;
      end
      S_JALR_PC: begin
        pc_update  = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'b0110011;
  logic        mem_ready = 1'b0;
  logic        pc_update, branch, ir_wr, reg_wr, mem_wr, adr_src, illegal;
  logic [1:0]  alu_src_a, alu_src_b, alu_opcode, result_src, imm_src;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  // {pc_update, branch, ir_wr, reg_wr, mem_wr, adr_src, a, b, alu, result}
  localparam logic [13:0] V_FETCH_R  = 14'b101000_00_10_00_10;
  localparam logic [13:0] V_FETCH_W  = 14'b000000_00_10_00_10;
  localparam logic [13:0] V_DECODE   = 14'b000000_01_01_00_00;
  localparam logic [13:0] V_MEM_ADR  = 14'b000000_10_01_00_00;
  localparam logic [13:0] V_MEM_RD   = 14'b000001_00_00_00_00;
  localparam logic [13:0] V_MEM_WB   = 14'b000100_00_00_00_01;
  localparam logic [13:0] V_MEM_WR   = 14'b000011_00_00_00_00;
  localparam logic [13:0] V_EXEC_R   = 14'b000000_10_00_10_00;
  localparam logic [13:0] V_EXEC_I   = 14'b000000_10_01_10_00;
  localparam logic [13:0] V_ALU_WB   = 14'b000100_00_00_00_00;
  localparam logic [13:0] V_BRANCH   = 14'b010000_10_00_01_00;
  localparam logic [13:0] V_JAL      = 14'b100000_01_10_00_00;
  localparam logic [13:0] V_JALR_LNK = 14'b000000_01_10_00_00;
  localparam logic [13:0] V_JALR_TGT = 14'b000100_10_01_00_00;
  localparam logic [13:0] V_JALR_PC  = 14'b100000_00_00_00_00;
  localparam logic [13:0] V_TRAP     = 14'b000000_00_00_00_00;

  logic [13:0] outs;
  assign outs = {pc_update, branch, ir_wr, reg_wr, mem_wr, adr_src,
                 alu_src_a, alu_src_b, alu_opcode, result_src};

  multicycle_controller #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_update  (pc_update),
    .branch     (branch),
    .ir_wr      (ir_wr),
    .reg_wr     (reg_wr),
    .mem_wr     (mem_wr),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_opcode (alu_opcode),
    .result_src (result_src),
    .imm_src    (imm_src),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock period: drive mem_ready mid-cycle, then check the state's outputs
  task automatic step(input string tag, input logic rdy, input logic [13:0] exp);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    check(tag, {18'd0, outs}, {18'd0, exp});
  endtask

  // Idle FETCH cycle (no fetch) followed by a retired-count check
  task automatic idle_retired(input string tag, input int exp);
    step({tag, "_idle"}, 1'b0, V_FETCH_W);
    check({tag, "_retired"}, retired, exp);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_outs", {18'd0, outs}, {18'd0, V_FETCH_W});
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add: 4 cycles, mem_ready tied high
    opcode = 7'b0110011;
    step("add_fetch", 1'b1, V_FETCH_R);
    check("add_imm", {30'd0, imm_src}, 32'd0);
    step("add_decode", 1'b1, V_DECODE);
    step("add_exec", 1'b1, V_EXEC_R);
    step("add_wb", 1'b1, V_ALU_WB);
    idle_retired("add", 1);

    // load: 2 wait cycles in FETCH and in MEM_RD, 9 cycles total
    opcode = 7'b0000011;
    step("ld_fetch_w0", 1'b0, V_FETCH_W);
    step("ld_fetch_w1", 1'b0, V_FETCH_W);
    step("ld_fetch", 1'b1, V_FETCH_R);
    step("ld_decode", 1'b0, V_DECODE);
    step("ld_adr", 1'b0, V_MEM_ADR);
    step("ld_rd_w0", 1'b0, V_MEM_RD);
    step("ld_rd_w1", 1'b0, V_MEM_RD);
    step("ld_rd", 1'b1, V_MEM_RD);
    step("ld_wb", 1'b0, V_MEM_WB);
    idle_retired("ld", 2);

    // store: 3 wait cycles in MEM_WR, mem_wr held for 4 cycles
    opcode = 7'b0100011;
    step("st_fetch", 1'b1, V_FETCH_R);
    check("st_imm", {30'd0, imm_src}, 32'd1);
    step("st_decode", 1'b1, V_DECODE);
    step("st_adr", 1'b1, V_MEM_ADR);
    step("st_wr_w0", 1'b0, V_MEM_WR);
    step("st_wr_w1", 1'b0, V_MEM_WR);
    step("st_wr_w2", 1'b0, V_MEM_WR);
    step("st_wr", 1'b1, V_MEM_WR);
    idle_retired("st", 3);

    // jalr: 5 cycles
    opcode = 7'b1100111;
    step("jalr_fetch", 1'b1, V_FETCH_R);
    step("jalr_decode", 1'b1, V_DECODE);
    step("jalr_link", 1'b1, V_JALR_LNK);
    step("jalr_tgt", 1'b1, V_JALR_TGT);
    step("jalr_pc", 1'b1, V_JALR_PC);
    idle_retired("jalr", 4);

    // branch: 3 cycles
    opcode = 7'b1100011;
    step("beq_fetch", 1'b1, V_FETCH_R);
    check("beq_imm", {30'd0, imm_src}, 32'd2);
    step("beq_decode", 1'b1, V_DECODE);
    step("beq_exec", 1'b1, V_BRANCH);
    idle_retired("beq", 5);

    // jal: 4 cycles
    opcode = 7'b1101111;
    step("jal_fetch", 1'b1, V_FETCH_R);
    check("jal_imm", {30'd0, imm_src}, 32'd3);
    step("jal_decode", 1'b1, V_DECODE);
    step("jal_exec", 1'b1, V_JAL);
    step("jal_wb", 1'b1, V_ALU_WB);
    idle_retired("jal", 6);

    // addi: 4 cycles
    opcode = 7'b0010011;
    step("addi_fetch", 1'b1, V_FETCH_R);
    step("addi_decode", 1'b1, V_DECODE);
    step("addi_exec", 1'b1, V_EXEC_I);
    step("addi_wb", 1'b1, V_ALU_WB);
    idle_retired("addi", 7);

    // illegal opcode: trap is sticky, counter frozen
    opcode = 7'b1111111;
    step("trap_fetch", 1'b1, V_FETCH_R);
    step("trap_decode", 1'b1, V_DECODE);
    step("trap_0", 1'b1, V_TRAP);
    check("trap_illegal", {31'd0, illegal}, 32'd1);
    step("trap_1", 1'b1, V_TRAP);
    step("trap_2", 1'b0, V_TRAP);
    check("trap_illegal_held", {31'd0, illegal}, 32'd1);
    check("trap_retired", retired, 32'd7);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("trap_rst_outs", {18'd0, outs}, {18'd0, V_FETCH_W});
    check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
    check("trap_rst_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset asserted mid-cycle during a MEM_WR stall
    opcode = 7'b0100011;
    step("ab_fetch", 1'b1, V_FETCH_R);
    step("ab_decode", 1'b1, V_DECODE);
    step("ab_adr", 1'b1, V_MEM_ADR);
    step("ab_wr_w0", 1'b0, V_MEM_WR);
    @(posedge clk);
    #3;
    check("ab_pre_mem_wr", {31'd0, mem_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ab_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("ab_outs", {18'd0, outs}, {18'd0, V_FETCH_W});
    check("ab_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // normal operation resumes after the abort
    opcode = 7'b0110011;
    step("post_fetch", 1'b1, V_FETCH_R);
    step("post_decode", 1'b1, V_DECODE);
    step("post_exec", 1'b1, V_EXEC_R);
    step("post_wb", 1'b1, V_ALU_WB);
    idle_retired("post", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
